// File: rtl/pipe_stage_buf_if.sv
// Valid/ready/data handshake bundle between two pipeline stages.
// The producer uses the master modport and the consumer uses the slave modport.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with a valid/ready handshake, an optional 2-entry skid buffer and a synchronous flush.
// While no valid entry is held, dn.data shows NOP_VALUE so that the consumer sees a bubble.
module pipe_stage_buf #(
  parameter int               DATA_W    = 128,
  parameter bit               SKID_EN   = 1'b1,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_buf_if.slave       up,
  pipe_stage_buf_if.master      dn,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  logic w_upFire;
  logic w_dnFire;

  assign w_upFire = up.valid & up.ready;
  assign w_dnFire = dn.valid & dn.ready;

  generate
    if (SKID_EN) begin : g_skid
      state_t            r_state;
      logic [DATA_W-1:0] r_main;
      logic [DATA_W-1:0] r_skid;
      logic              r_upReady;

      // r_upReady always mirrors (r_state != TWO). It is kept as its own flop so that up.ready has no combinational path.
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          r_state   <= EMPTY;
          r_main    <= NOP_VALUE;
          r_skid    <= NOP_VALUE;
          r_upReady <= 1'b1;
        end else begin
          case (r_state)
            EMPTY: begin
              if (w_upFire) begin
                r_main  <= up.data;
                r_state <= ONE;
              end
            end
            ONE: begin
              if (w_upFire && !w_dnFire) begin
                r_skid    <= up.data;
                r_state   <= TWO;
                r_upReady <= 1'b0;
              end else if (w_upFire && w_dnFire) begin
                r_main <= up.data;
              end else if (w_dnFire) begin
                r_main  <= NOP_VALUE;
                r_state <= EMPTY;
              end
            end
            TWO: begin
              if (w_dnFire) begin
                r_main    <= r_skid;
                r_skid    <= NOP_VALUE;
                r_state   <= ONE;
                r_upReady <= 1'b1;
              end
            end
            default: begin
              r_state   <= EMPTY;
              r_main    <= NOP_VALUE;
              r_skid    <= NOP_VALUE;
              r_upReady <= 1'b1;
            end
          endcase
        end
      end

      assign up.ready  = r_upReady;
      assign dn.valid  = (r_state != EMPTY);
      assign dn.data   = r_main;
      assign occupancy = {r_state == TWO, r_state == ONE};
    end else begin : g_noSkid
      logic [DATA_W-1:0] r_main;
      logic              r_valid;

      // A single register. A new entry can load in the same cycle that the old one drains, so no bubble appears.
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          r_main  <= NOP_VALUE;
          r_valid <= 1'b0;
        end else if (w_upFire) begin
          r_main  <= up.data;
          r_valid <= 1'b1;
        end else if (w_dnFire) begin
          r_main  <= NOP_VALUE;
          r_valid <= 1'b0;
        end
      end

      assign up.ready  = !r_valid | dn.ready;
      assign dn.valid  = r_valid;
      assign dn.data   = r_main;
      assign occupancy = {1'b0, r_valid};
    end
  endgenerate

endmodule
